// File: rtl/pc_packer_pkg.sv
// rtl/pc_packer_pkg.sv - shared constants and helpers for the PC word packer
//
// Purpose: common definitions imported by pc_word_packer and pc_packer_ram.
//   clog2          : ceiling log2 used to size the sub-word index counter
//   PAD_VALUE      : bit value used to fill unwritten sub-words of a flushed word
//   RATIO_MIN/MAX  : legal range of sub-words per output word
//   DEPTH_LOG2_MIN : smallest supported storage depth exponent
package pc_packer_pkg;

  localparam bit PAD_VALUE      = 1'b0;
  localparam int RATIO_MIN      = 1;
  localparam int RATIO_MAX      = 8;
  localparam int DEPTH_LOG2_MIN = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_packer_ram.sv
// rtl/pc_packer_ram.sv - simple dual-port word store for the PC word packer
//
// Purpose: 2^ADDR_W x DATA_W array, one write port, one registered read port.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read enable and address; rdata updates on enabled edges
//   rdata           : registered read data, 0 after reset
// In show-ahead mode the read register follows the next head every cycle, and a
// write landing on that same address is forwarded so a word written into an
// empty store is visible on the cycle empty falls.
module pc_packer_ram #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int SHOW_AHEAD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              fwd;

  // Normal mode never forwards: when full, a pop and a commit share the head
  // slot and the pop must return the old contents.
  assign fwd = (SHOW_AHEAD != 0) && we && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= fwd ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/pc_word_packer.sv
// rtl/pc_word_packer.sv - width-converting FIFO packing narrow PC words into SDRAM words
//
// Purpose: packs RATIO WIDTH_IN sub-words (first at the LSBs) into one wide word
// and buffers up to 2^DEPTH_LOG2 wide words.
// Optional feature macro: PC_PACKER_FLUSH_EN (flush commits a zero-padded
// partial word; when undefined the flush port is ignored).
// Ports:
//   sys_clk, rst          : clock, asynchronous active-high reset
//   wr_data, wr_ena       : input sub-word and its strobe
//   flush                 : commit partial word (PC_PACKER_FLUSH_EN only)
//   rd_req                : pop head word (ignored while empty)
//   rd_data, rd_valid     : output word and its valid flag
//   empty, full           : registered storage status
//   used_words, burst_rdy : stored word count and count >= BURST_LEN
//   overflow, clr_ovf     : sticky dropped-word flag and its clear
module pc_word_packer
  import pc_packer_pkg::*;
#(
  parameter int WIDTH_IN   = 8,
  parameter int RATIO      = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter int BURST_LEN  = 8,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [WIDTH_IN-1:0]       wr_data,
  input  logic                      wr_ena,
  input  logic                      flush,
  input  logic                      rd_req,
  input  logic                      clr_ovf,
  output logic [WIDTH_IN*RATIO-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic [DEPTH_LOG2:0]       used_words,
  output logic                      burst_rdy,
  output logic                      overflow
);

  localparam int WIDTH_OUT = WIDTH_IN * RATIO;
  localparam int IDX_W     = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
  localparam int CNT_W     = DEPTH_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CAPACITY  = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [CNT_W-1:0] BURST_THR = CNT_W'(BURST_LEN);

  logic [IDX_W-1:0]      sub_idx;
  logic [WIDTH_OUT-1:0]  pack_reg;
  logic [WIDTH_OUT-1:0]  pack_next;
  logic                  word_done;
  logic                  flush_commit;
  logic                  commit;
  logic                  pop;
  logic                  do_write;
  logic                  drop;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_en;
  logic [CNT_W-1:0]      used_next;

  // Insert the incoming sub-word at the current index. The accumulator is
  // cleared after every commit, so unwritten upper sub-words are already padding.
  always_comb begin
    pack_next = pack_reg;
    if (wr_ena) begin
      for (int k = 0; k < RATIO; k++) begin
        if (sub_idx == IDX_W'(k)) pack_next[k*WIDTH_IN +: WIDTH_IN] = wr_data;
      end
    end
  end

  assign word_done = wr_ena && (sub_idx == LAST_IDX);

`ifdef PC_PACKER_FLUSH_EN
  // A coincident write counts, so flush with wr_ena at index 0 still commits.
  assign flush_commit = flush && ((sub_idx != '0) || wr_ena);
`else
  assign flush_commit = flush & 1'b0;
`endif

  assign commit   = word_done || flush_commit;
  assign pop      = rd_req && !empty;
  // A pop in the same cycle frees the head slot, so a commit while full fits.
  assign do_write = commit && (!full || pop);
  assign drop     = commit && full && !pop;

  assign rd_ptr_next = pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
  assign rd_addr     = (SHOW_AHEAD != 0) ? rd_ptr_next : rd_ptr;
  assign rd_en       = (SHOW_AHEAD != 0) ? 1'b1 : pop;

  always_comb begin
    used_next = used_words;
    if (do_write && !pop)      used_next = used_words + CNT_W'(1);
    else if (pop && !do_write) used_next = used_words - CNT_W'(1);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sub_idx  <= '0;
      pack_reg <= {WIDTH_OUT{PAD_VALUE}};
    end else if (commit) begin
      sub_idx  <= '0;
      pack_reg <= {WIDTH_OUT{PAD_VALUE}};
    end else if (wr_ena) begin
      sub_idx  <= sub_idx + IDX_W'(1);
      pack_reg <= pack_next;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used_words <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      burst_rdy  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr     <= rd_ptr_next;
      used_words <= used_next;
      empty      <= (used_next == '0);
      full       <= (used_next == CAPACITY);
      burst_rdy  <= (used_next >= BURST_THR);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign rd_valid = !empty;
    end else begin : g_normal
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= pop;
      end
    end
  endgenerate

  pc_packer_ram #(
    .ADDR_W     (DEPTH_LOG2),
    .DATA_W     (WIDTH_OUT),
    .SHOW_AHEAD (SHOW_AHEAD)
  ) u_ram (
    .clk   (sys_clk),
    .rst   (rst),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (pack_next),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
